muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EXE stage, alongside the single-cycle ALU.
- Executes MULT, MULTU, DIV and DIVU on the same operands the ALU receives.
- Owns the architectural HI/LO registers and raises busy, so the hazard logic stalls the pipeline until done.
- MTHI/MTLO write HI/LO directly; MFHI/MFLO read the hi/lo outputs.

Parameters:
- WIDTH, 32, operand width and width of the HI and LO registers.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request: launch the operation given by op on val1/val2.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- val1  input  WIDTH  multiplicand or dividend (rs).
- val2  input  WIDTH  multiplier or divisor (rt).
- flush  input  1  synchronous cancel of the operation in flight.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when a result has been written to HI/LO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - Iteration counter and working registers cleared.
  - Takes effect mid-operation with no done pulse.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge E0: latch op, |val1|, |val2| (magnitudes for signed ops, raw values for unsigned ops) and the sign flags; count=0; go to RUN; busy=1 from E0.
  - start=0: done=0.
- RUN:
  - One iteration per edge, count 0..WIDTH-1.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per edge.
  - At the edge where count=WIDTH-1 (E(WIDTH), i.e. E32 at default):
    - Sign-correct the result.
    - Write hi/lo.
    - Set done=1 for exactly one cycle, busy=0, return to IDLE.
  - Latency: result visible WIDTH cycles after the start edge.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product. Signed product is negated when the operand signs differ.
- Divide result:
  - lo = quotient, truncated toward zero; negated when the operand signs differ.
  - hi = remainder; takes the sign of the dividend.
- Divide by zero (either DIV or DIVU):
  - lo = all ones, hi = val1 unmodified.
  - Still takes WIDTH cycles and pulses done.
- DIV of most-negative value by -1: lo = 0x80000000, hi = 0 (wraps, no trap).
- start while busy: ignored; the in-flight operation is unaffected.
- flush while busy:
  - Return to IDLE at that edge; busy=0; hi/lo unchanged; no done pulse.
  - start in the same cycle as flush is ignored.
- flush while idle: no effect.
- hi_we/lo_we:
  - Accepted only in IDLE; at the edge, write wdata to HI/LO.
  - Ignored while busy.
  - In IDLE together with start: the write happens at E0 and the later result overwrites it.
- The result write and done share the same edge, so hi/lo are valid whenever done=1.
- op, val1 and val2 are sampled only at the start edge; later changes have no effect.

Test Plan:
- Reset, then MULT val1=0xFFFFFFFD (-3), val2=5 -> busy for 32 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 32 cycles after start; start pulses mid-run are ignored.
- DIV:
  - -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064, done after 32 cycles.
- MTHI 0x1234 in IDLE -> hi=0x1234. Then start DIVU 10/3 and assert flush on cycle 10 -> busy drops, no done, hi stays 0x1234, lo unchanged. A new DIVU 10/3 -> lo=3, hi=1.
- rst_n low at cycle 15 of a MULT -> busy=0, hi=lo=0 immediately, no done. After release, start is accepted on the next edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit. Owns the HI/LO registers, runs
// shift-add multiply and restoring divide one bit per clock, and raises
// busy while an operation is in flight so the pipeline can stall.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;   // result (product/quotient) needs negation
  logic                 neg_rem_q, neg_rem_d;   // remainder follows a negative dividend
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     a_q, a_d;               // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;           // {partial product | remainder, multiplier | quotient}
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // Operand magnitudes and signs at the launch edge
  logic             is_signed;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;

  // One iteration of the multiply or divide datapath
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Datapath: operand conditioning, one iteration, and final sign correction
  always_comb begin
    is_signed = ~op[0];
    s1        = is_signed & val1[WIDTH-1];
    s2        = is_signed & val2[WIDTH-1];
    mag1      = s1 ? -val1 : val1;
    mag2      = s2 ? -val2 : val2;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = rem_shift - {1'b0, a_q};
    if (div_diff[WIDTH]) begin
      div_next = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    step     = is_div_q ? div_next : mul_next;
    prod_fix = neg_res_q ? -step : step;
    // Divide by zero: quotient all ones; remainder path already restores val1
    quo_fix  = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
    rem_fix  = neg_rem_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  end

  // Next-state logic: launch, iterate, flush, result write and MTHI/MTLO
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    a_d       = a_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d   = RUN;
          count_d   = '0;
          is_div_d  = op[1];
          neg_res_d = s1 ^ s2;
          neg_rem_d = s1;
          div0_d    = op[1] & (val2 == '0);
          if (op[1]) begin
            a_d   = mag2;
            acc_d = {{WIDTH{1'b0}}, mag1};
          end else begin
            a_d   = mag1;
            acc_d = {{WIDTH{1'b0}}, mag2};
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = step;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous clear of all working state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] val1;
  logic [31:0] val2;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .val1  (val1),
    .val2  (val2),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start for one edge (E0), then scramble operands to show they are not re-sampled.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; val1 = a; val2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    val1 = $urandom;
    val2 = $urandom;
  endtask

  // Count edges after E0 until done is seen; bounded.
  task automatic wait_done(output int cycles, output bit seen);
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; op = 0; val1 = 0; val2 = 0;
    flush = 0; hi_we = 0; lo_we = 0; wdata = 0;
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_mult_signed();
    int cyc; bit seen;
    launch(2'b00, 32'hFFFFFFFD, 32'd5);
    total_cnt++; if (busy !== 1'b1) $display("FAIL mult_busy_e0: got %b want 1", busy); else pass_cnt++;
    wait_done(cyc, seen);
    total_cnt++; if (!seen || cyc != 32) $display("FAIL mult_latency: got %0d (seen=%b) want 32", cyc, seen); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_lo: got %h want fffffff1", lo); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mult_busy_done: got %b want 0", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b want 0", done); else pass_cnt++;
    $display("MULT -3*5: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_multu_ignore_start();
    int cyc; bit seen;
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cyc = 0; seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      cyc = c;
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      // Stray start requests mid-run must not disturb the operation.
      start = (c == 5 || c == 12);
      op = 2'b10; val1 = 32'd1; val2 = 32'd1;
    end
    start = 1'b0;
    total_cnt++; if (!seen || cyc != 32) $display("FAIL multu_latency: got %0d (seen=%b) want 32", cyc, seen); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", lo); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL multu_after: got done=%b busy=%b want 0 0", done, busy); else pass_cnt++;
    $display("MULTU ffffffff*ffffffff: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_div_signed();
    int cyc; bit seen;
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, seen);
    total_cnt++; if (!seen || cyc != 32) $display("FAIL div_latency: got %0d (seen=%b) want 32", cyc, seen); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want fffffffd", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want ffffffff", hi); else pass_cnt++;
    $display("DIV -7/2: cycles=%0d hi=%h lo=%h", cyc, hi, lo);

    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, seen);
    total_cnt++; if (!seen) $display("FAIL divovf_done: got no done want done"); else pass_cnt++;
    total_cnt++; if (lo !== 32'h80000000) $display("FAIL divovf_lo: got %h want 80000000", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL divovf_hi: got %h want 00000000", hi); else pass_cnt++;
    $display("DIV 80000000/ffffffff: cycles=%0d hi=%h lo=%h", cyc, hi, lo);

    launch(2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done(cyc, seen);
    total_cnt++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) $display("FAIL div_pos_neg: got hi=%h lo=%h want 00000001 fffffffd", hi, lo); else pass_cnt++;
    $display("DIV 7/-2: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_divu_zero();
    int cyc; bit seen;
    launch(2'b11, 32'd100, 32'd0);
    wait_done(cyc, seen);
    total_cnt++; if (!seen || cyc != 32) $display("FAIL divu0_latency: got %0d (seen=%b) want 32", cyc, seen); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFFF) $display("FAIL divu0_lo: got %h want ffffffff", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'h00000064) $display("FAIL divu0_hi: got %h want 00000064", hi); else pass_cnt++;
    $display("DIVU 100/0: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_mthi_flush();
    int cyc; bit seen; bit done_seen;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    total_cnt++; if (hi !== 32'h1234) $display("FAIL mthi: got %h want 00001234", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFFF) $display("FAIL mthi_lo_kept: got %h want ffffffff", lo); else pass_cnt++;
    $display("MTHI 1234: hi=%h lo=%h", hi, lo);

    launch(2'b11, 32'd10, 32'd3);
    done_seen = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    // MTLO while busy must be ignored; flush lands on cycle 10, with a stray start.
    flush = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD0000; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; lo_we = 1'b0; start = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else pass_cnt++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    total_cnt++; if (done_seen !== 1'b0) $display("FAIL flush_no_done: got %b want 0", done_seen); else pass_cnt++;
    total_cnt++; if (hi !== 32'h1234) $display("FAIL flush_hi: got %h want 00001234", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFFF) $display("FAIL flush_lo: got %h want ffffffff", lo); else pass_cnt++;
    $display("DIVU 10/3 flushed: busy=%b hi=%h lo=%h", busy, hi, lo);

    launch(2'b11, 32'd10, 32'd3);
    wait_done(cyc, seen);
    total_cnt++; if (!seen || cyc != 32) $display("FAIL divu_latency: got %0d (seen=%b) want 32", cyc, seen); else pass_cnt++;
    total_cnt++; if (lo !== 32'd3) $display("FAIL divu_lo: got %h want 00000003", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd1) $display("FAIL divu_hi: got %h want 00000001", hi); else pass_cnt++;
    $display("DIVU 10/3: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  task automatic test_async_reset();
    int cyc; bit seen;
    launch(2'b00, 32'd7, 32'd9);
    for (int c = 1; c <= 14; c++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL areset_hilo: got hi=%h lo=%h want 0 0", hi, lo); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL areset_done: got %b want 0", done); else pass_cnt++;
    $display("async reset mid-MULT: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launch(2'b00, 32'd7, 32'd9);
    total_cnt++; if (busy !== 1'b1) $display("FAIL post_reset_start: got busy=%b want 1", busy); else pass_cnt++;
    wait_done(cyc, seen);
    total_cnt++; if (!seen || hi !== 32'h0 || lo !== 32'd63) $display("FAIL post_reset_mult: got seen=%b hi=%h lo=%h want 1 0 3f", seen, hi, lo); else pass_cnt++;
    $display("MULT 7*9 after reset: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu_ignore_start();
    test_div_signed();
    test_divu_zero();
    test_mthi_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
